// File: rtl/lcd_bus_arbiter_pkg.sv
// lcd_bus_arbiter_pkg: shared FSM states, LCD command codes and long-settle command detection
package lcd_bus_arbiter_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_HI_STB,
        S_HI_GAP,
        S_LO_STB,
        S_LO_GAP,
        S_WAIT
    } state_t;

    localparam logic [7:0] LCD_CMD_CLEAR = 8'h01;
    localparam logic [7:0] LCD_CMD_HOME  = 8'h02;

    // Clear/home style commands need the long settle time before the next byte
    function automatic logic is_long_cmd(input logic cmd_rs, input logic [7:0] cmd);
        return !cmd_rs && (cmd == LCD_CMD_CLEAR || cmd == LCD_CMD_HOME || cmd == 8'h03);
    endfunction

endpackage

// File: rtl/lcd_bus_arbiter_if.sv
// lcd_bus_arbiter_if: requester handshake and 4-bit LCD bus bundle
interface lcd_bus_arbiter_if #(
    parameter int NUM_REQ = 2
);
    logic [NUM_REQ-1:0]   req_valid;
    logic [NUM_REQ-1:0]   req_rs;
    logic [8*NUM_REQ-1:0] req_data;
    logic [NUM_REQ-1:0]   req_lock;
    logic [NUM_REQ-1:0]   req_ready;
    logic [NUM_REQ-1:0]   grant;
    logic                 busy;
    logic                 en;
    logic                 rs;
    logic [3:0]           data;

    modport master (
        output req_valid, req_rs, req_data, req_lock,
        input  req_ready, grant, busy, en, rs, data
    );

    modport slave (
        input  req_valid, req_rs, req_data, req_lock,
        output req_ready, grant, busy, en, rs, data
    );
endinterface

// File: rtl/lcd_bus_arbiter_rr_arbiter.sv
// lcd_rr_arbiter: round-robin pick of the first valid requester at/after a registered pointer
module lcd_rr_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int IW      = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] valid,
    input  logic               advance,
    input  logic [IW-1:0]      last,
    output logic [NUM_REQ-1:0] pick,
    output logic [IW-1:0]      pick_idx,
    output logic               any
);
    logic [IW-1:0] ptr;
    logic [IW-1:0] k;

    // Pointer moves one past the owner that just released the bus
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            ptr <= '0;
        else if (advance)
            ptr <= (int'(last) == NUM_REQ - 1) ? '0 : last + 1'b1;
    end

    // Scan from the farthest offset down so the nearest valid requester wins
    always_comb begin
        pick_idx = '0;
        any      = 1'b0;
        k        = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            k = IW'((int'(ptr) + i) % NUM_REQ);
            if (valid[k]) begin
                pick_idx = k;
                any      = 1'b1;
            end
        end
        pick = NUM_REQ'(any) << pick_idx;
    end
endmodule

// File: rtl/lcd_bus_arbiter.sv
// lcd_bus_arbiter: shares a 4-bit HD44780 bus between byte requesters; LCD_ARB_LOCK_TIMEOUT_EN enables idle-lock timeout
module lcd_bus_arbiter
    import lcd_bus_arbiter_pkg::*;
#(
    parameter int NUM_REQ    = 2,
    parameter int SHORT_WAIT = 1,
    parameter int LONG_WAIT  = 2
`ifdef LCD_ARB_LOCK_TIMEOUT_EN
    ,
    parameter int LOCK_TIMEOUT = 8
`endif
) (
    input logic               clk,
    input logic               reset,
    lcd_bus_arbiter_if.slave  bus
);
    localparam int IW = (NUM_REQ > 2) ? 2 : 1;

    state_t             state, state_n;
    logic [NUM_REQ-1:0] grant_q;
    logic [IW-1:0]      gidx;
    logic               gvld;
    logic [3:0]         lo_q;
    logic [3:0]         data_q;
    logic               rs_q;
    logic               long_q;
    logic [7:0]         wcnt;
    int                 wait_len;
    logic               accept;
    logic               release_g;
    logic [7:0]         sel_byte;
    logic               sel_valid;
    logic               sel_lock;
    logic               sel_rs;
    logic [NUM_REQ-1:0] pick;
    logic [IW-1:0]      pick_idx;
    logic               pick_any;
    logic               tout;

    assign gvld      = |grant_q;
    assign sel_valid = bus.req_valid[gidx];
    assign sel_lock  = bus.req_lock[gidx];
    assign sel_rs    = bus.req_rs[gidx];
    assign wait_len  = long_q ? LONG_WAIT : SHORT_WAIT;

    // Byte lane of the current grantee
    always_comb begin
        sel_byte = '0;
        for (int i = 0; i < NUM_REQ; i++)
            if (gidx == IW'(i)) sel_byte = bus.req_data[8*i +: 8];
    end

    lcd_rr_arbiter #(.NUM_REQ(NUM_REQ), .IW(IW)) u_rr (
        .clk      (clk),
        .reset    (reset),
        .valid    (bus.req_valid),
        .advance  (release_g),
        .last     (gidx),
        .pick     (pick),
        .pick_idx (pick_idx),
        .any      (pick_any)
    );

`ifdef LCD_ARB_LOCK_TIMEOUT_EN
    logic [15:0] tcnt;
    assign tout = state == S_IDLE && gvld && !sel_valid && sel_lock && int'(tcnt) >= LOCK_TIMEOUT - 1;
    // Counts idle cycles a locked grantee holds the bus without offering a byte
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            tcnt <= '0;
        else
            tcnt <= (state == S_IDLE && gvld && !sel_valid && sel_lock && !tout) ? tcnt + 1'b1 : '0;
    end
`else
    assign tout = 1'b0;
`endif

    // FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= S_IDLE;
        else
            state <= state_n;
    end

    // Next state, accept and grant release; unlocked grantees release on every return to idle
    always_comb begin
        state_n   = state;
        accept    = 1'b0;
        release_g = 1'b0;
        case (state)
            S_IDLE: begin
                accept    = gvld && sel_valid;
                release_g = gvld && !sel_valid && (!sel_lock || tout);
                state_n   = accept ? S_HI_STB : S_IDLE;
            end
            S_HI_STB: state_n = S_HI_GAP;
            S_HI_GAP: state_n = S_LO_STB;
            S_LO_STB: state_n = S_LO_GAP;
            S_LO_GAP: state_n = (wait_len == 0) ? S_IDLE : S_WAIT;
            S_WAIT:   state_n = (int'(wcnt) >= wait_len - 1) ? S_IDLE : S_WAIT;
            default:  state_n = S_IDLE;
        endcase
        if (state != S_IDLE && state_n == S_IDLE) release_g = !sel_lock;
    end

    // Byte latch, nibble sequencing, settle counter and grant ownership
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            grant_q <= '0;
            gidx    <= '0;
            lo_q    <= '0;
            data_q  <= '0;
            rs_q    <= 1'b0;
            long_q  <= 1'b0;
            wcnt    <= '0;
        end else begin
            wcnt <= (state == S_WAIT) ? wcnt + 1'b1 : '0;
            if (accept) begin
                rs_q   <= sel_rs;
                data_q <= sel_byte[7:4];
                lo_q   <= sel_byte[3:0];
                long_q <= is_long_cmd(sel_rs, sel_byte);
            end
            if (state == S_HI_GAP) data_q <= lo_q;
            if (release_g)
                grant_q <= '0;
            else if (state == S_IDLE && !gvld && pick_any) begin
                grant_q <= pick;
                gidx    <= pick_idx;
            end
        end
    end

    assign bus.req_ready = accept ? grant_q : '0;
    assign bus.grant     = grant_q;
    assign bus.busy      = state != S_IDLE;
    assign bus.en        = state == S_HI_STB || state == S_LO_STB;
    assign bus.rs        = rs_q;
    assign bus.data      = data_q;
endmodule

// File: tb/tb_lcd_bus_arbiter.sv
// tb_lcd_bus_arbiter: transaction-timeline model plus directed tests for lcd_bus_arbiter
module tb_lcd_bus_arbiter;
    localparam int LOCK_TIMEOUT = 8;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    lcd_bus_arbiter_if #(.NUM_REQ(2)) bus ();

    lcd_bus_arbiter #(.NUM_REQ(2), .SHORT_WAIT(1), .LONG_WAIT(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Requester queues: entry = {lock, rs, data}
    logic [9:0] mem[2][16];
    int         head[2] = '{0, 0};
    int         tail[2] = '{0, 0};
    logic [1:0] idle_lock = 2'b00;
    logic [1:0] hs = 2'b00;
    logic [9:0] cur;

    task automatic push(input int i, input logic lk, input logic r, input logic [7:0] d);
        mem[i][tail[i]] = {lk, r, d};
        tail[i]++;
    endtask

    initial begin
        bus.req_valid = '0;
        bus.req_rs    = '0;
        bus.req_lock  = '0;
        bus.req_data  = '0;
        forever begin
            @(negedge clk);
            hs = bus.req_valid & bus.req_ready;
            @(posedge clk);
            #1;
            for (int i = 0; i < 2; i++) begin
                if (hs[i]) head[i]++;
                bus.req_valid[i] = head[i] < tail[i];
                cur = bus.req_valid[i] ? mem[i][head[i]] : {idle_lock[i], 9'h0};
                bus.req_lock[i] = cur[9];
                bus.req_rs[i]   = cur[8];
                bus.req_data[8*i +: 8] = cur[7:0];
            end
        end
    end

    // Model: owner, RR pointer and cycles since the last accept
    int         owner = -1, ptr = 0, since = -1, w = 0, tcnt = 0;
    logic [7:0] mb = '0;
    logic       mrs = 1'b0;
    logic [3:0] mlast = '0;
    logic       tout_m;
    int         e_busy, e_en, e_data, e_grant, e_ready;
    int         n_acc = 0;
    int         acc_cyc[32];
    int         acc_who[32];

    always @(negedge clk) begin
        if (reset) begin
            owner = -1; ptr = 0; since = -1; tcnt = 0; mrs = 1'b0; mlast = '0;
        end else begin
            if (|(bus.req_valid & bus.req_ready)) begin
                acc_cyc[n_acc] = cyc;
                acc_who[n_acc] = bus.req_ready[1] ? 1 : 0;
                n_acc++;
            end
            e_busy  = (since >= 1) ? 1 : 0;
            e_en    = (since == 1 || since == 3) ? 1 : 0;
            e_data  = (since >= 1 && since <= 2) ? int'(mb[7:4]) : (since >= 3) ? int'(mb[3:0]) : int'(mlast);
            e_grant = (owner >= 0) ? (1 << owner) : 0;
            e_ready = (since < 0 && owner >= 0 && bus.req_valid[owner]) ? (1 << owner) : 0;
            check("busy", int'(bus.busy), e_busy);
            check("en", int'(bus.en), e_en);
            check("rs", int'(bus.rs), int'(mrs));
            check("data", int'(bus.data), e_data);
            check("grant", int'(bus.grant), e_grant);
            check("ready", int'(bus.req_ready), e_ready);
`ifdef LCD_ARB_LOCK_TIMEOUT_EN
            tout_m = tcnt == LOCK_TIMEOUT - 1;
`else
            tout_m = 1'b0;
`endif
            if (since < 0) begin
                if (owner >= 0 && bus.req_valid[owner]) begin
                    mb    = bus.req_data[8*owner +: 8];
                    mrs   = bus.req_rs[owner];
                    w     = (!mrs && (mb == 8'h01 || mb == 8'h02 || mb == 8'h03)) ? 2 : 1;
                    since = 1;
                    tcnt  = 0;
                end else if (owner >= 0 && (!bus.req_lock[owner] || tout_m)) begin
                    ptr   = (owner + 1) % 2;
                    owner = -1;
                    tcnt  = 0;
                end else if (owner >= 0) begin
                    tcnt++;
                end else begin
                    for (int k = 0; k < 2; k++)
                        if (owner < 0 && bus.req_valid[(ptr + k) % 2]) owner = (ptr + k) % 2;
                end
            end else begin
                since++;
                if (since == 5 + w) begin
                    since = -1;
                    mlast = mb[3:0];
                    if (!bus.req_lock[owner]) begin
                        ptr   = (owner + 1) % 2;
                        owner = -1;
                    end
                end
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_n(input int t);
        int k = 0;
        while (n_acc < t && k < 80) begin
            tick();
            k++;
        end
        check("accept_count", n_acc, t);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    int t1_en[6]   = '{1, 0, 1, 0, 0, 0};
    int t1_data[6] = '{4, 4, 1, 1, 1, 1};
    int t1_busy[6] = '{1, 1, 1, 1, 1, 0};
    int t3_who[4]  = '{0, 1, 0, 1};
    int t4_who[4]  = '{1, 1, 1, 0};
    int base, strobes, k, t0;

    initial begin
        do_reset();
        tick();
        check("rst_en", int'(bus.en), 0);
        check("rst_rs", int'(bus.rs), 0);
        check("rst_data", int'(bus.data), 0);
        check("rst_grant", int'(bus.grant), 0);
        check("rst_busy", int'(bus.busy), 0);
        check("rst_ready", int'(bus.req_ready), 0);

        // 1: single data byte, nibble strobes and short settle
        base = n_acc;
        push(0, 1'b0, 1'b1, 8'h41);
        wait_n(base + 1);
        check("t1_ready", int'(bus.req_ready), 1);
        check("t1_grant", int'(bus.grant), 1);
        for (int i = 0; i < 6; i++) begin
            tick();
            check("t1_en", int'(bus.en), t1_en[i]);
            check("t1_data", int'(bus.data), t1_data[i]);
            check("t1_busy", int'(bus.busy), t1_busy[i]);
        end
        check("t1_rs", int'(bus.rs), 1);
        check("t1_grant_rel", int'(bus.grant), 0);

        // 2: locked clear command then data byte; long settle spacing
        base = n_acc;
        push(0, 1'b1, 1'b0, 8'h01);
        push(0, 1'b1, 1'b1, 8'h42);
        wait_n(base + 2);
        check("t2_spacing", acc_cyc[base + 1] - acc_cyc[base], 7);

        // 3: both requesters continuously valid after reset, no lock
        do_reset();
        base = n_acc;
        push(0, 1'b0, 1'b1, 8'h30);
        push(1, 1'b0, 1'b1, 8'h31);
        push(0, 1'b0, 1'b1, 8'h32);
        push(1, 1'b0, 1'b1, 8'h33);
        wait_n(base + 4);
        for (int i = 0; i < 4; i++) check("t3_order", acc_who[base + i], t3_who[i]);

        // 4: requester 1 locks for three bytes while requester 0 waits
        base = n_acc;
        push(1, 1'b1, 1'b1, 8'h50);
        push(1, 1'b1, 1'b1, 8'h51);
        push(1, 1'b1, 1'b0, 8'h38);
        k = 0;
        while (bus.grant != 2'b10 && k < 40) begin
            tick();
            k++;
        end
        check("t4_grant1", int'(bus.grant), 2);
        push(0, 1'b0, 1'b1, 8'h52);
        wait_n(base + 4);
        for (int i = 0; i < 4; i++) check("t4_order", acc_who[base + i], t4_who[i]);

        // 5: async reset during the low-nibble strobe
        base = n_acc;
        push(0, 1'b0, 1'b1, 8'h5A);
        wait_n(base + 1);
        repeat (3) tick();
        check("t5_lo_en", int'(bus.en), 1);
        reset = 1'b1;
        #1;
        check("t5_en", int'(bus.en), 0);
        check("t5_rs", int'(bus.rs), 0);
        check("t5_data", int'(bus.data), 0);
        check("t5_grant", int'(bus.grant), 0);
        check("t5_busy", int'(bus.busy), 0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        strobes = 0;
        repeat (6) begin
            tick();
            strobes += int'(bus.en);
        end
        check("t5_no_strobe", strobes, 0);

`ifdef LCD_ARB_LOCK_TIMEOUT_EN
        // 6: idle locked grantee loses the bus after the timeout
        do_reset();
        idle_lock[0] = 1'b1;
        base = n_acc;
        push(0, 1'b1, 1'b1, 8'h60);
        wait_n(base + 1);
        t0 = cyc;
        push(1, 1'b0, 1'b1, 8'h61);
        k = 0;
        while (bus.grant != 2'b10 && k < 40) begin
            tick();
            k++;
        end
        check("t6_grant", int'(bus.grant), 2);
        check("t6_delay", cyc - t0, 15);
        idle_lock[0] = 1'b0;
`endif

        repeat (8) tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors %0d", errors);
        $fatal(1, "watchdog");
    end
endmodule
